dmem_scanner: RTL
=================

Name: dmem_scanner

Overview:
- Read-side debug master for the data memory. Once the processor has halted, it walks a configurable word-address window of dmem, latches each word and holds it for display for a fixed dwell time.
- Presents address/data to the 7-segment display7 instances and flags completion.
- Sits beside the processor on the dmem read port. The top level muxes dmem address to the scanner while the scanner is busy.

Parameters:
- ADDR_START, 0, first byte address scanned; bits [1:0] ignored (forced to 0).
- ADDR_END, 100, last byte address scanned (inclusive); bits [1:0] ignored.
- HOLD_CYCLES, 50_000_000, dwell cycles per word (1 s at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 26, width of the dwell counter.

Ports:
- clk_50Mhz  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level/pulse request to begin a scan, sampled in IDLE and DONE only.
- step  input  1  asynchronous push-button; a rising edge skips the remaining dwell.
- rd_en  output  1  dmem read strobe, one cycle per word.
- rd_addr  output  32  dmem byte address, word aligned.
- rd_data  input  32  dmem read data, valid one cycle after rd_en (synchronous read).
- cur_addr  output  32  address of the word currently shown.
- cur_data  output  32  latched word currently shown.
- word_idx  output  8  index of the shown word from ADDR_START; wraps at 256.
- valid  output  1  cur_addr/cur_data hold a captured word.
- busy  output  1  scan in progress (REQ, WAIT, SHOW).
- done  output  1  scan finished.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, dwell counter 0, step synchronizer cleared.
- States: IDLE, REQ, WAIT, SHOW, DONE.
- IDLE: start=1 -> addr<=ADDR_START&~3, word_idx<=0, go to REQ.
- REQ (1 cycle): rd_en=1, rd_addr=addr -> WAIT.
- WAIT (1 cycle): cur_data<=rd_data, cur_addr<=addr, valid<=1, dwell counter<=0 -> SHOW.
- Read latency: rd_en to valid rising is 2 cycles.
- rd_en=0 and rd_addr=0 outside REQ.
- SHOW: the dwell counter increments each cycle. The dwell ends when counter==HOLD_CYCLES-1 or a step edge is detected, whichever comes first.
- At dwell end: if addr>=(ADDR_END&~3) -> DONE. Otherwise addr<=addr+4, word_idx<=word_idx+1, go to REQ.
- valid stays 1 through REQ/WAIT of the next word: the previous word is displayed until it is replaced. cur_* update only in WAIT.
- DONE: done=1, busy=0, last word stays displayed with valid=1. start=1 -> restart exactly as from IDLE, with done<=0 on the same edge.
- start while busy is ignored; a scan is never restarted mid-way.
- step handling: 2-flop synchronizer plus rising-edge detect. The edge takes effect 3 cycles after the pin rises.
  - An edge outside SHOW is discarded, not queued.
  - A held button produces exactly one edge.
- Simultaneous events: a step edge in the cycle the counter hits terminal counts as one advance only.
- Boundaries:
  - ADDR_START>ADDR_END: exactly one word (ADDR_START) is read, then DONE.
  - ADDR_START==ADDR_END: one word.
  - addr+4 overflow past 0xFFFFFFFC cannot occur because the >= check precedes the increment.
- HOLD_CYCLES=1: each word is shown for exactly 1 SHOW cycle, so each word takes 3 cycles in total.
- Reset mid-scan: immediate return to IDLE with all outputs 0. The bench checks rd_en drops asynchronously.
- All arithmetic is unsigned; word_idx wraps 255->0 with no flag.

Test Plan:
- Reset: hold reset=0 with start=1 for 5 cycles -> all outputs 0, state IDLE. Release -> REQ on the next edge with rd_addr=0.
- Full scan, HOLD_CYCLES=4, ADDR_START=0, ADDR_END=12, dmem preloaded {0x11,0x22,0x33,0x44}:
  - rd_en pulses at addresses 0,4,8,12.
  - cur_data sequence 0x11..0x44, each held 4 SHOW cycles, word_idx 0..3.
  - done=1 after 24 cycles from start, with cur_data=0x44.
- Step skip, HOLD_CYCLES=1000: raise step during the first SHOW -> advance to REQ 3 cycles after the pin rises. Holding step high gives no further advance. Step pressed in IDLE gives no effect.
- Program check, ADDR_START=ADDR_END=100 with dmem[100]=7 -> a single read, cur_addr=100, cur_data=7, then done=1.
- Restart and ignore: start pulsed in SHOW -> ignored. start in DONE -> done clears and rd_addr=ADDR_START on the next REQ.
- Reset mid-scan: assert reset during WAIT -> outputs 0 immediately (asynchronous, not on the next clock edge). Release and start again -> the scan begins at ADDR_START with word_idx=0.

Source files
------------

// File: rtl/dmem_scanner.sv
// dmem_scanner: after halt, walks a word window of dmem and holds each word for display
// for a fixed dwell, with a push-button step that skips the remaining dwell.
module dmem_scanner #(
    parameter logic [31:0] ADDR_START  = 32'd0,
    parameter logic [31:0] ADDR_END    = 32'd100,
    parameter int          HOLD_CYCLES = 50_000_000,
    parameter int          CNT_W       = 26
) (
    input  logic        clk_50Mhz,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] cur_addr,
    output logic [31:0] cur_data,
    output logic [7:0]  word_idx,
    output logic        valid,
    output logic        busy,
    output logic        done
);
    localparam logic [31:0]      LP_START = ADDR_START & ~32'd3;
    localparam logic [31:0]      LP_END   = ADDR_END & ~32'd3;
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHOW, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_addr, r_cur_addr, r_cur_data;
    logic [7:0]       r_idx;
    logic             r_valid, r_step_q;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_step_edge, w_dwell_end, w_last, w_launch;

    assign w_step_edge = r_sync[1] & ~r_step_q;
    assign w_dwell_end = (r_state == S_SHOW) && (r_cnt == LP_LAST || w_step_edge);
    assign w_last      = r_addr >= LP_END;
    assign w_launch    = (r_state == S_IDLE || r_state == S_DONE) && start;

    assign rd_en    = r_state == S_REQ;
    assign rd_addr  = rd_en ? r_addr : 32'd0;
    assign busy     = r_state == S_REQ || r_state == S_WAIT || r_state == S_SHOW;
    assign done     = r_state == S_DONE;
    assign cur_addr = r_cur_addr;
    assign cur_data = r_cur_data;
    assign word_idx = r_idx;
    assign valid    = r_valid;

    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = start ? S_REQ : r_state;
            S_REQ:          w_next = S_WAIT;
            S_WAIT:         w_next = S_SHOW;
            S_SHOW:         w_next = !w_dwell_end ? S_SHOW : (w_last ? S_DONE : S_REQ);
            default:        w_next = S_IDLE;
        endcase
    end

    // A step edge seen outside SHOW is simply dropped; the edge detector never queues it.
    always_ff @(posedge clk_50Mhz or negedge reset) begin
        if (!reset) begin
            r_sync     <= '0;
            r_step_q   <= 1'b0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_cur_addr <= '0;
            r_cur_data <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync   <= {r_sync[0], step};
            r_step_q <= r_sync[1];
            if (w_launch) begin
                r_addr <= LP_START;
                r_idx  <= '0;
            end
            if (r_state == S_WAIT) begin
                r_cur_data <= rd_data;
                r_cur_addr <= r_addr;
                r_valid    <= 1'b1;
                r_cnt      <= '0;
            end
            if (r_state == S_SHOW && !w_dwell_end) r_cnt <= r_cnt + 1'b1;
            if (w_dwell_end && !w_last) begin
                r_addr <= r_addr + 32'd4;
                r_idx  <= r_idx + 8'd1;
            end
        end
    end
endmodule
